memory_load_aligner: RTL

//  Read-side counterpart of the store column decoder; sits between data memory and LSU writeback.

---
 rtl/memory_load_aligner_pkg.sv | 24 ++
 rtl/memory_load_aligner_extract.sv | 36 +++
 rtl/memory_load_aligner.sv | 124 ++++++++++++
 3 files changed

// File: rtl/memory_load_aligner_pkg.sv
// Shared load/store types: access size encoding, per-load metadata carried
// through the read-latency pipe, and the buffered response record.
package memory_load_aligner_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;

  typedef struct packed {
    logic [1:0]  offset;
    mem_access_t access;
    logic        is_unsigned;
    logic [4:0]  rd;
  } load_meta_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        misaligned;
  } load_rsp_t;

endpackage

// File: rtl/memory_load_aligner_extract.sv
// Combinational lane select and sign/zero extension of a returned memory word.
// Illegal or misaligned accesses return zero with the misaligned flag set.
module memory_load_extract
  import memory_load_aligner_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  mem_access_t access_i,
  input  logic        is_unsigned_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = word_i[{offset_i, 3'b000} +: 8];
    half_sel     = offset_i[1] ? word_i[31:16] : word_i[15:0];
    data_o       = '0;
    misaligned_o = 1'b0;
    case (access_i)
      MEM_ACCESS_BYTE: data_o = {{24{byte_sel[7] & ~is_unsigned_i}}, byte_sel};
      MEM_ACCESS_HALF: begin
        if (offset_i[0]) misaligned_o = 1'b1;
        else             data_o = {{16{half_sel[15] & ~is_unsigned_i}}, half_sel};
      end
      MEM_ACCESS_WORD: begin
        if (offset_i != 2'b00) misaligned_o = 1'b1;
        else                   data_o = word_i;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_load_aligner.sv
// Load-side aligner: tracks requests through the RAM read latency, extracts the
// addressed lane and buffers results so writeback may stall.
module memory_load_aligner
  import memory_load_aligner_pkg::*;
#(
  parameter int L            = 128,
  parameter int W            = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [$clog2(L)-1:0] req_addr,
  input  mem_access_t          req_access,
  input  logic                 req_unsigned,
  input  logic [4:0]           req_rd,
  input  logic [W-1:0]         mem_rd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_data,
  output logic [4:0]           rsp_rd,
  output logic                 rsp_misaligned
);

  localparam int AW    = $clog2(L);
  localparam int DEPTH = READ_LATENCY + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  if (W != 32) begin : g_bad_width
    $error("memory_load_aligner: only W=32 is supported");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("memory_load_aligner: READ_LATENCY must be 1..4");
  end

  logic                    accept, push, pop;
  logic [READ_LATENCY-1:0] valid_q;
  load_meta_t              meta_q [READ_LATENCY];
  load_meta_t              meta_in;
  load_rsp_t               buf_q [DEPTH];
  load_rsp_t               ext_rsp;
  logic [31:0]             ext_data;
  logic                    ext_mis;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d, inflight;
  logic [CW:0]             credit_used;
  logic                    unused_addr_hi;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_addr_hi = ^req_addr[AW-1:2];
  assign meta_in = '{offset: req_addr[1:0], access: req_access,
                     is_unsigned: req_unsigned, rd: req_rd};
  assign accept    = req_valid & req_ready;
  assign push      = valid_q[READ_LATENCY-1];
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(valid_q[i]);
  end

  // A head entry leaving this cycle frees its slot for the request being accepted,
  // which keeps back-to-back loads flowing with only READ_LATENCY+1 entries.
  always_comb begin
    credit_used = {1'b0, inflight} + {1'b0, count_q} - (CW + 1)'(pop);
    req_ready   = credit_used < (CW + 1)'(DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) meta_q[i] <= '0;
    end else begin
      valid_q[0] <= accept;
      meta_q[0]  <= meta_in;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        meta_q[i]  <= meta_q[i-1];
      end
    end
  end

  memory_load_extract u_extract (
    .offset_i      (meta_q[READ_LATENCY-1].offset),
    .access_i      (meta_q[READ_LATENCY-1].access),
    .is_unsigned_i (meta_q[READ_LATENCY-1].is_unsigned),
    .word_i        (mem_rd_data),
    .data_o        (ext_data),
    .misaligned_o  (ext_mis)
  );

  assign ext_rsp = '{data: ext_data, rd: meta_q[READ_LATENCY-1].rd, misaligned: ext_mis};

  always_comb begin
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) buf_q[wr_ptr_q] <= ext_rsp;
    end
  end

  assign rsp_data       = buf_q[rd_ptr_q].data;
  assign rsp_rd         = buf_q[rd_ptr_q].rd;
  assign rsp_misaligned = buf_q[rd_ptr_q].misaligned;

endmodule
